// File: rtl/video_shifter.sv
// Video line fetcher and MSB-first pixel serialiser: pulls one line of bitmap
// bytes from shared video RAM through a 2-entry queue and shifts one pixel per clock.
//   state | meaning
//   IDLE  | no line in progress, fetcher parked
//   DELAY | line accepted, prefetching while the start delay runs down
//   SHIFT | active pixels, one byte slot every 8 cycles
module video_shifter #(
  parameter int BYTES_PER_LINE = 24,
  parameter int LINE_COUNT     = 256,
  parameter int START_DELAY    = 8,
  parameter int ADDR_WIDTH     = 13
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_start_i,
  input  logic                  line_start_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [7:0]            mem_data_i,
  output logic                  pixel_o,
  output logic                  active_o,
  output logic                  underrun_o
);

  localparam int CW = $clog2(BYTES_PER_LINE + 1);
  localparam int LW = $clog2(LINE_COUNT + 1);
  localparam int DW = $clog2(START_DELAY);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         delay_q, delay_d;
  logic [LW-1:0]         line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [CW-1:0]         fetch_cnt_q, fetch_cnt_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [7:0]            q0_q, q0_d, q1_q, q1_d;
  logic [1:0]            q_cnt_q, q_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [2:0]            bit_q, bit_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  underrun_q, underrun_d;

  logic                  accept, last_slot, slot_start, pop, push;
  logic [LW-1:0]         line_cnt_eff;
  logic [ADDR_WIDTH-1:0] line_base_eff;

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    line_cnt_d   = line_cnt_q;
    line_base_d  = line_base_q;
    fetch_addr_d = fetch_addr_q;
    fetch_cnt_d  = fetch_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    q0_d         = q0_q;
    q1_d         = q1_q;
    q_cnt_d      = q_cnt_q;
    shreg_d      = shreg_q;
    bit_d        = bit_q;
    req_d        = req_q;
    addr_d       = addr_q;
    discard_d    = discard_q;
    underrun_d   = underrun_q;

    // frameStart takes effect before a lineStart in the same cycle
    line_cnt_eff  = frame_start_i ? '0 : line_cnt_q;
    line_base_eff = frame_start_i ? '0 : line_base_q;
    if (frame_start_i) begin
      line_cnt_d  = '0;
      line_base_d = '0;
      underrun_d  = 1'b0;
    end

    accept     = line_start_i && (line_cnt_eff < LW'(LINE_COUNT));
    last_slot  = (slot_cnt_q == CW'(BYTES_PER_LINE - 1));
    slot_start = !accept && (((state_q == DELAY) && (delay_q == '0)) ||
                             ((state_q == SHIFT) && (bit_q == 3'd7) && !last_slot));
    pop        = slot_start && (q_cnt_q != 2'd0);
    push       = mem_ack_i && req_q && !discard_q && (state_q != IDLE) && !accept;

    case (state_q)
      DELAY:   if (delay_q == '0) state_d = SHIFT;
               else delay_d = delay_q - DW'(1);
      SHIFT:   if ((bit_q == 3'd7) && last_slot) state_d = IDLE;
      default: ;
    endcase

    if (state_q == SHIFT) begin
      shreg_d = {shreg_q[6:0], 1'b0};
      bit_d   = bit_q + 3'd1;
    end
    if (slot_start) begin
      shreg_d = pop ? q0_q : 8'h00;
      bit_d   = 3'd0;
      if (!pop) underrun_d = 1'b1;
      if (state_q == SHIFT) slot_cnt_d = slot_cnt_q + CW'(1);
    end

    case ({push, pop})
      2'b10: begin
        if (q_cnt_q == 2'd0) q0_d = mem_data_i;
        else q1_d = mem_data_i;
        q_cnt_d = q_cnt_q + 2'd1;
      end
      2'b01: begin
        q0_d    = q1_q;
        q_cnt_d = q_cnt_q - 2'd1;
      end
      2'b11: begin
        if (q_cnt_q == 2'd1) q0_d = mem_data_i;
        else begin
          q0_d = q1_q;
          q1_d = mem_data_i;
        end
      end
      default: ;
    endcase

    // a request is only raised if its byte is guaranteed a free queue slot
    if (req_q && mem_ack_i) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (push) begin
        fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
        fetch_cnt_d  = fetch_cnt_q + CW'(1);
      end
    end else if (!req_q && (state_q != IDLE) && (state_d != IDLE) && !accept &&
                 (fetch_cnt_q < CW'(BYTES_PER_LINE)) &&
                 ((q_cnt_q - {1'b0, pop}) < 2'd2)) begin
      req_d  = 1'b1;
      addr_d = fetch_addr_q;
    end

    if (accept) begin
      state_d      = DELAY;
      delay_d      = DW'(START_DELAY - 1);
      line_cnt_d   = line_cnt_eff + LW'(1);
      fetch_addr_d = line_base_eff;
      line_base_d  = line_base_eff + ADDR_WIDTH'(BYTES_PER_LINE);
      fetch_cnt_d  = '0;
      slot_cnt_d   = '0;
      q_cnt_d      = 2'd0;
      bit_d        = 3'd0;
      if (req_q && !mem_ack_i) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      delay_q      <= '0;
      line_cnt_q   <= '0;
      line_base_q  <= '0;
      fetch_addr_q <= '0;
      fetch_cnt_q  <= '0;
      slot_cnt_q   <= '0;
      q0_q         <= 8'h00;
      q1_q         <= 8'h00;
      q_cnt_q      <= 2'd0;
      shreg_q      <= 8'h00;
      bit_q        <= 3'd0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      discard_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      line_cnt_q   <= line_cnt_d;
      line_base_q  <= line_base_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      q_cnt_q      <= q_cnt_d;
      shreg_q      <= shreg_d;
      bit_q        <= bit_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign active_o   = (state_q == SHIFT);
  assign pixel_o    = active_o && shreg_q[7];
  assign underrun_o = underrun_q;

  queue_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && !pop && (q_cnt_q == 2'd2)));

endmodule
